// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch address, IF/ID register, fault flags and statistics counters.
// Latency: one cycle from a PC value to its instruction in IF/ID; a redirect costs one bubble.
// Backpressure: stall freezes PC and IF/ID; a redirect presented during a stall is ignored.
//
// Ports:
//   clk, reset                 - single clock, synchronous active-high reset
//   stall                      - hazard-unit hold
//   branch_taken/branch_target - ID-stage taken branch and its byte address
//   jump/jump_target           - ID-stage jump and its byte address (wins over branch)
//   inst_addr/inst_in          - combinational instruction-memory port
//   pc                         - current PC
//   if_id_inst/_pc_plus4/_valid - IF/ID pipeline register
//   pc_oob, misalign           - sticky fault flags
//   fetch_count, stall_count, redirect_count - statistics counters
module fetch_stage #(
    parameter int                    data_size = 32,
    parameter logic [data_size-1:0]  reset_pc  = '0,
    parameter int                    mem_size  = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [data_size-1:0] branch_target,
    input  logic                 jump,
    input  logic [data_size-1:0] jump_target,
    output logic [data_size-1:0] inst_addr,
    input  logic [data_size-1:0] inst_in,
    output logic [data_size-1:0] pc,
    output logic [data_size-1:0] if_id_inst,
    output logic [data_size-1:0] if_id_pc_plus4,
    output logic                 if_id_valid,
    output logic                 pc_oob,
    output logic                 misalign,
    output logic [31:0]          fetch_count,
    output logic [31:0]          stall_count,
    output logic [31:0]          redirect_count
);

    // One extra bit so a memory depth at the top of the PC range still compares correctly.
    localparam logic [data_size:0] MEM_WORDS = (data_size + 1)'(mem_size);

    logic [data_size-1:0] r_pc;
    logic [data_size-1:0] r_if_id_inst;
    logic [data_size-1:0] r_if_id_pc_plus4;
    logic                 r_if_id_valid;
    logic                 r_pc_oob;
    logic                 r_misalign;
    logic [31:0]          r_fetch_count;
    logic [31:0]          r_stall_count;
    logic [31:0]          r_redirect_count;

    logic                 w_redirect;
    logic [data_size-1:0] w_raw_target;
    logic [data_size-1:0] w_target;
    logic [data_size-1:0] w_pc_plus4;
    logic [data_size:0]   w_pc_word;
    logic                 w_pc_out_of_range;

    assign w_redirect   = jump | branch_taken;
    assign w_raw_target = jump ? jump_target : branch_target;
    assign w_target     = {w_raw_target[data_size-1:2], 2'b00};
    assign w_pc_plus4   = r_pc + data_size'(4);
    assign w_pc_word    = {3'b000, r_pc[data_size-1:2]};

    // Once out of range the PC holds, so it stays out of range until a redirect
    // moves it; the range check alone therefore implements the sticky hold and
    // lets an in-range redirect release it.
    assign w_pc_out_of_range = (w_pc_word >= MEM_WORDS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc             <= reset_pc;
            r_if_id_inst     <= '0;
            r_if_id_pc_plus4 <= '0;
            r_if_id_valid    <= 1'b0;
            r_pc_oob         <= 1'b0;
            r_misalign       <= 1'b0;
            r_fetch_count    <= '0;
            r_stall_count    <= '0;
            r_redirect_count <= '0;
        end else if (stall) begin
            r_stall_count <= r_stall_count + 32'd1;
        end else if (w_redirect) begin
            r_pc             <= w_target;
            r_if_id_inst     <= '0;
            r_if_id_pc_plus4 <= '0;
            r_if_id_valid    <= 1'b0;
            r_redirect_count <= r_redirect_count + 32'd1;
            if (w_raw_target[1:0] != 2'b00) begin
                r_misalign <= 1'b1;
            end
        end else if (w_pc_out_of_range) begin
            r_if_id_inst     <= '0;
            r_if_id_pc_plus4 <= '0;
            r_if_id_valid    <= 1'b0;
            r_pc_oob         <= 1'b1;
        end else begin
            r_pc             <= w_pc_plus4;
            r_if_id_inst     <= inst_in;
            r_if_id_pc_plus4 <= w_pc_plus4;
            r_if_id_valid    <= 1'b1;
            r_fetch_count    <= r_fetch_count + 32'd1;
        end
    end

    assign inst_addr      = r_pc;
    assign pc             = r_pc;
    assign if_id_inst     = r_if_id_inst;
    assign if_id_pc_plus4 = r_if_id_pc_plus4;
    assign if_id_valid    = r_if_id_valid;
    assign pc_oob         = r_pc_oob;
    assign misalign       = r_misalign;
    assign fetch_count    = r_fetch_count;
    assign stall_count    = r_stall_count;
    assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized redirects/stalls/resets,
// every cycle compared against a behavioural model of the fetch rules.
// Instruction memory is a 64-word table driven combinationally from inst_addr.
module tb_fetch_stage;

    localparam int MEM = 32;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target, inst_addr, inst_in, pc;
    logic [31:0] if_id_inst, if_id_pc_plus4;
    logic        if_id_valid, pc_oob, misalign;
    logic [31:0] fetch_count, stall_count, redirect_count;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_pc, m_inst, m_pc4, m_fetch, m_stall, m_redir;
    logic        m_valid, m_oob, m_mis;

    always #5 clk = ~clk;

    assign inst_in = mem[inst_addr[7:2]];

    fetch_stage #(.data_size(32), .reset_pc(32'h0), .mem_size(MEM)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .inst_addr(inst_addr), .inst_in(inst_in), .pc(pc),
        .if_id_inst(if_id_inst), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .pc_oob(pc_oob), .misalign(misalign),
        .fetch_count(fetch_count), .stall_count(stall_count),
        .redirect_count(redirect_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the fetch rules to the model for one rising edge.
    task automatic model_edge(input logic rst, input logic st, input logic br,
                              input logic [31:0] bt, input logic j, input logic [31:0] jt);
        logic [31:0] t;
        if (rst) begin
            m_pc = 32'h0; m_inst = 0; m_pc4 = 0; m_valid = 0;
            m_oob = 0; m_mis = 0; m_fetch = 0; m_stall = 0; m_redir = 0;
        end else if (st) begin
            m_stall = m_stall + 1;
        end else if (j || br) begin
            t = j ? jt : bt;
            if (t % 4 != 0) m_mis = 1;
            m_pc = t - (t % 4);
            m_inst = 0; m_pc4 = 0; m_valid = 0;
            m_redir = m_redir + 1;
        end else if (m_pc / 4 >= MEM) begin
            m_oob = 1;
            m_inst = 0; m_pc4 = 0; m_valid = 0;
        end else begin
            m_inst = mem[(m_pc / 4) % 64];
            m_pc4 = m_pc + 4;
            m_valid = 1;
            m_pc = m_pc + 4;
            m_fetch = m_fetch + 1;
        end
    endtask

    task automatic check_all();
        check("pc", pc, m_pc);
        check("inst_addr", inst_addr, m_pc);
        check("if_id_inst", if_id_inst, m_inst);
        check("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        check("pc_oob", {31'b0, pc_oob}, {31'b0, m_oob});
        check("misalign", {31'b0, misalign}, {31'b0, m_mis});
        check("fetch_count", fetch_count, m_fetch);
        check("stall_count", stall_count, m_stall);
        check("redirect_count", redirect_count, m_redir);
    endtask

    // Drive inputs, take one edge, update model, compare 1 time unit later.
    task automatic step(input logic rst, input logic st, input logic br,
                        input logic [31:0] bt, input logic j, input logic [31:0] jt);
        reset = rst; stall = st; branch_taken = br; branch_target = bt;
        jump = j; jump_target = jt;
        @(posedge clk);
        model_edge(rst, st, br, bt, j, jt);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020; mem[3] = 32'h0000_0000;
        reset = 1; stall = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_target = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h40, 1, 32'h80);
        check("reset_pc_const", pc, 32'h0);
        check("reset_valid_const", {31'b0, if_id_valid}, 32'h0);

        // Free run of four instructions
        for (int i = 0; i < 4; i++) begin
            idle();
            check("run_pc4_const", if_id_pc_plus4, 32'(4 * (i + 1)));
        end
        check("run_fetch_const", fetch_count, 32'd4);

        // Stall for three cycles
        for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h40, 0, 0);
        check("stall_count_const", stall_count, 32'd3);
        check("stall_pc_const", pc, 32'h10);
        idle();

        // Branch, then jump+branch, then jump with stall held
        step(0, 0, 1, 32'h40, 0, 0);
        check("branch_pc_const", pc, 32'h40);
        idle();
        check("branch_pc4_const", if_id_pc_plus4, 32'h44);
        step(0, 0, 1, 32'h40, 1, 32'h50);
        check("jump_wins_const", pc, 32'h50);
        step(0, 1, 1, 32'h40, 1, 32'h60);
        check("stall_redirect_const", pc, 32'h50);

        // Misaligned jump, cleared by reset
        step(0, 0, 0, 0, 1, 32'h23);
        check("misalign_pc_const", pc, 32'h20);
        check("misalign_flag_const", {31'b0, misalign}, 32'h1);
        step(1, 0, 0, 0, 0, 0);

        // Free run past the end of memory
        for (int i = 0; i < MEM + 4; i++) idle();
        check("oob_pc_const", pc, 32'(MEM * 4));
        check("oob_fetch_const", fetch_count, 32'(MEM));
        // In-range redirect releases the hold
        step(0, 0, 1, 32'h8, 0, 0);
        idle();
        check("oob_release_valid_const", {31'b0, if_id_valid}, 32'h1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0), 32'($urandom_range(0, 8'hA3)),
                 ($urandom_range(0, 9) == 0), 32'($urandom_range(0, 8'hA3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
